// File: rtl/mem_arbiter.sv
//==============================================================================
// Module : mem_arbiter
// Brief  : Shares one single-ported, fixed-latency main memory between the
//          instruction-cache fill path and the data-cache fill/write path.
//          Block fills issue one read per cycle; returned words are steered
//          to their owner via a tag pipeline matching the memory latency.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   output logic                           i_ack,
   input  logic                           d_req,
   input  logic                           d_we,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           d_ack,
   output logic                           fill_valid,
   output logic                           fill_dst,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_offset,
   output logic [DATA_W-1:0]              fill_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   output logic                           busy
);

   localparam int OFF_W  = $clog2(BLOCK_WORDS);
   localparam int CNT_W  = OFF_W + 1;
   localparam int WCNT_W = $clog2(LATENCY + 1);

   // Clears the word-offset and byte bits to get the block base address.
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_IFILL = 3'd1,
      S_DFILL = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4,
      S_TURN  = 3'd5
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;         // next word index to issue
   logic [WCNT_W-1:0]   wcnt;        // remaining drain / write-busy cycles
   logic                last_grant;  // 0 = I, 1 = D
   logic                cur_dst;     // owner of the current transaction
   logic [ADDR_W-1:0]   req_addr;    // address captured at grant
   logic                ack_pulse;
   logic                grant_d;
   logic                grant_i;

   // Tag pipeline: one entry per cycle of memory latency.
   logic [LATENCY-1:0]  sr_v;
   logic [LATENCY-1:0]  sr_d;
   logic [OFF_W-1:0]    sr_k [LATENCY];

   // On a conflict the side that did not win last time gets the memory.
   assign grant_d = d_req & (~i_req | ~last_grant);
   assign grant_i = i_req & ~grant_d;

   // Transaction sequencer with registered memory-side outputs and ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         wcnt       <= '0;
         last_grant <= 1'b0;
         cur_dst    <= 1'b0;
         req_addr   <= '0;
         ack_pulse  <= 1'b0;
         mem_en     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         ack_pulse <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (grant_d) begin
                  last_grant <= 1'b1;
                  cur_dst    <= 1'b1;
                  req_addr   <= d_addr;
                  mem_en     <= 1'b1;
                  if (d_we) begin
                     state     <= S_WRITE;
                     mem_wr    <= 1'b1;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     wcnt      <= WCNT_W'(LATENCY);
                  end else begin
                     state     <= S_DFILL;
                     mem_wr    <= 1'b0;
                     mem_addr  <= d_addr & BLK_MASK;
                     cnt       <= CNT_W'(1);
                  end
               end else if (grant_i) begin
                  last_grant <= 1'b0;
                  cur_dst    <= 1'b0;
                  req_addr   <= i_addr;
                  state      <= S_IFILL;
                  mem_en     <= 1'b1;
                  mem_wr     <= 1'b0;
                  mem_addr   <= i_addr & BLK_MASK;
                  cnt        <= CNT_W'(1);
               end
            end
            S_IFILL, S_DFILL: begin
               if (cnt == CNT_LAST) begin
                  // Last read already on the bus; wait for returns.
                  state     <= S_DRAIN;
                  mem_en    <= 1'b0;
                  mem_addr  <= '0;
                  wcnt      <= WCNT_W'(LATENCY - 1);
                  ack_pulse <= (LATENCY == 1);
               end else begin
                  mem_addr <= (req_addr & BLK_MASK) |
                              {{(ADDR_W-OFF_W-1){1'b0}}, cnt[OFF_W-1:0], 1'b0};
                  cnt      <= cnt + CNT_W'(1);
               end
            end
            S_DRAIN, S_WRITE: begin
               mem_en    <= 1'b0;
               mem_wr    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (wcnt == '0) begin
                  state <= S_TURN;
               end else begin
                  wcnt      <= wcnt - WCNT_W'(1);
                  ack_pulse <= (wcnt == WCNT_W'(1));
               end
            end
            S_TURN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Each read issue pushes its owner and word index; the entry reaches the
   // end of the pipeline exactly when the memory returns that word.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_v <= '0;
         sr_d <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            sr_k[i] <= '0;
         end
      end else begin
         sr_v[0] <= mem_en & ~mem_wr;
         sr_d[0] <= mem_en & ~mem_wr & cur_dst;
         sr_k[0] <= (mem_en & ~mem_wr) ? mem_addr[OFF_W:1] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            sr_v[i] <= sr_v[i-1];
            sr_d[i] <= sr_d[i-1];
            sr_k[i] <= sr_k[i-1];
         end
      end
   end

   assign fill_valid  = sr_v[LATENCY-1];
   assign fill_dst    = sr_d[LATENCY-1];
   assign fill_offset = sr_k[LATENCY-1];
   assign fill_data   = fill_valid ? mem_rdata : '0;
   assign i_ack       = ack_pulse & ~cur_dst;
   assign d_ack       = ack_pulse & cur_dst;
   assign busy        = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter. A transaction-level model
//          predicts every output cycle by cycle from grant times; requesters
//          are queues, the memory is a latency pipe returning addr^0xA5A5.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int L  = 4;
   localparam int BW = 8;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam logic [15:0] MASK = ~16'(2 * BW - 1);

   logic                   clk, rst;
   logic                   i_req, i_ack, d_req, d_we, d_ack;
   logic [AW-1:0]          i_addr, d_addr, mem_addr;
   logic [DW-1:0]          d_wdata, fill_data, mem_wdata, mem_rdata;
   logic                   fill_valid, fill_dst, mem_en, mem_wr, busy;
   logic [$clog2(BW)-1:0]  fill_offset;

   mem_arbiter #(.LATENCY(L), .BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .fill_valid(fill_valid), .fill_dst(fill_dst), .fill_offset(fill_offset),
      .fill_data(fill_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-latency memory: read data = address ^ 0xA5A5, junk otherwise.
   logic        pv [L];
   logic [15:0] pa [L];
   logic [15:0] junk;
   always @(posedge clk) begin
      pv[0] <= mem_en && !mem_wr;
      pa[0] <= mem_addr;
      junk  <= 16'($urandom);
      for (int i = 1; i < L; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
   end
   assign mem_rdata = (pv[L-1] === 1'b1) ? (pa[L-1] ^ 16'hA5A5) : junk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

   req_t iq[$];
   req_t dq[$];

   int          errors, checks;
   int          cyc;
   bit          act;
   int          g, idle_at;
   bit          tdst, twe;
   logic [15:0] taddr, tbase, twdata;
   bit          last_grant;
   bit          checking;
   int          hold_mode;
   int          last_iack, last_dack, iack_cnt, fv_cnt, fv_d_cnt;
   int          r, w;

   function automatic req_t mk(input logic we, input logic [15:0] a, input logic [15:0] wd);
      req_t q;
      q.we = we; q.addr = a; q.wdata = wd;
      return q;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic start_txn(input bit dst, input bit we, input logic [15:0] a, input logic [15:0] wd);
      act        = 1'b1;
      g          = cyc;
      tdst       = dst;
      twe        = we;
      taddr      = a;
      tbase      = a & MASK;
      twdata     = wd;
      last_grant = dst;
      idle_at    = cyc + (we ? (L + 3) : (BW + L + 2));
   endtask

   // Round-robin decision in any cycle the arbiter is idle.
   task automatic model_grant();
      if (rst == 1'b0 && cyc >= idle_at) begin
         if (d_req && (!i_req || !last_grant)) start_txn(1'b1, d_we, d_addr, d_wdata);
         else if (i_req) start_txn(1'b0, 1'b0, i_addr, 16'h0);
      end
   endtask

   task automatic check_cycle();
      int d, off;
      bit en, wr, fv, ia, da, bz;
      logic [15:0] ea, ew;
      d = cyc - g;
      en = 0; wr = 0; fv = 0; ia = 0; da = 0; bz = 0; off = 0; ea = 0; ew = 0;
      if (act && cyc < idle_at) begin
         bz = (d >= 1);
         if (twe) begin
            if (d == 1) begin en = 1; wr = 1; ea = taddr; ew = twdata; end
            da = (d == L + 1);
         end else begin
            if (d >= 1 && d <= BW) begin en = 1; ea = tbase + 16'(2 * (d - 1)); end
            if (d >= L + 1 && d <= BW + L) begin fv = 1; off = d - 1 - L; end
            if (d == BW + L) begin
               if (tdst) da = 1; else ia = 1;
            end
         end
      end
      chk("mem_en", 32'(mem_en), 32'(en));
      chk("mem_wr", 32'(mem_wr), 32'(wr));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ew));
      chk("fill_valid", 32'(fill_valid), 32'(fv));
      chk("i_ack", 32'(i_ack), 32'(ia));
      chk("d_ack", 32'(d_ack), 32'(da));
      chk("busy", 32'(busy), 32'(bz));
      if (fv) begin
         chk("fill_dst", 32'(fill_dst), 32'(tdst));
         chk("fill_offset", 32'(fill_offset), 32'(off));
         chk("fill_data", 32'(fill_data), 32'((tbase + 16'(2 * off)) ^ 16'hA5A5));
      end
   endtask

   task automatic observe();
      if (i_ack === 1'b1) begin last_iack = cyc; iack_cnt++; end
      if (d_ack === 1'b1) last_dack = cyc;
      if (fill_valid === 1'b1) begin
         fv_cnt++;
         if (fill_dst === 1'b1) fv_d_cnt++;
      end
   endtask

   task automatic model_post();
      if (rst) begin
         act        = 1'b0;
         idle_at    = cyc + 1;
         last_grant = 1'b0;
         checking   = 1'b1;
      end else if (act && cyc == idle_at - 2) begin
         if (tdst) begin
            if (dq.size() != 0) void'(dq.pop_front());
         end else begin
            if (iq.size() != 0) void'(iq.pop_front());
         end
      end
   endtask

   // Requester behaviour: the owner may hold, withdraw or scramble its inputs
   // while its transaction runs; otherwise each side presents its queue head.
   task automatic drive_inputs();
      bit own_i, own_d;
      own_i = act && !tdst && cyc > g && cyc <= idle_at - 2;
      own_d = act &&  tdst && cyc > g && cyc <= idle_at - 2;
      if (own_i) begin
         case (hold_mode)
            0:       begin i_req = 1'b1;          i_addr = taddr; end
            1:       begin i_req = (cyc < g + 3); i_addr = 16'($urandom); end
            default: begin i_req = 1'($urandom);  i_addr = 16'($urandom); end
         endcase
      end else if (iq.size() != 0) begin
         i_req = 1'b1; i_addr = iq[0].addr;
      end else begin
         i_req = 1'b0; i_addr = 16'($urandom);
      end
      if (own_d) begin
         case (hold_mode)
            0:       begin d_req = 1'b1; d_we = twe; d_addr = taddr; d_wdata = twdata; end
            1:       begin d_req = (cyc < g + 3); d_we = 1'($urandom);
                           d_addr = 16'($urandom); d_wdata = 16'($urandom); end
            default: begin d_req = 1'($urandom); d_we = 1'($urandom);
                           d_addr = 16'($urandom); d_wdata = 16'($urandom); end
         endcase
      end else if (dq.size() != 0) begin
         d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
      end else begin
         d_req = 1'b0; d_we = 1'b0; d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
   endtask

   task automatic tick();
      drive_inputs();
      @(negedge clk);
      model_grant();
      observe();
      if (checking) check_cycle();
      @(posedge clk);
      model_post();
      cyc++;
      #1;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((cyc < idle_at || iq.size() != 0 || dq.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      chk("wait_idle_bound", 32'(n < limit), 32'(1));
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      act = 0; g = 0; idle_at = 0; last_grant = 0; checking = 0; hold_mode = 0;
      tdst = 0; twe = 0; taddr = 0; tbase = 0; twdata = 0;
      last_iack = -1; last_dack = -1; iack_cnt = 0; fv_cnt = 0; fv_d_cnt = 0;

      // Reset with both sides requesting; first conflict goes to D.
      rst = 1'b1;
      iq.push_back(mk(1'b0, 16'h0034, 16'h0));
      dq.push_back(mk(1'b0, 16'h2000, 16'h0));
      tick();
      tick();
      rst = 1'b0;
      r = cyc;
      while (cyc < r + 27) tick();
      chk("rr_d_first_ack", 32'(last_dack), 32'(r + 12));
      chk("rr_i_second_ack", 32'(last_iack), 32'(r + 26));

      // Fresh simultaneous requests after the I fill: D wins again.
      iq.push_back(mk(1'b0, 16'h0560, 16'h0));
      dq.push_back(mk(1'b0, 16'h0770, 16'h0));
      wait_idle(400);
      chk("rr_fresh_d_ack", 32'(last_dack), 32'(r + 40));
      chk("rr_fresh_i_ack", 32'(last_iack), 32'(r + 54));

      // Single-word write.
      w = cyc; fv_cnt = 0;
      dq.push_back(mk(1'b1, 16'h1002, 16'hBEEF));
      wait_idle(100);
      chk("wr_dack_cycle", 32'(last_dack - w), 32'(5));
      chk("wr_no_fill", 32'(fv_cnt), 32'(0));

      // D fill whose request drops in cycle 3 still completes.
      hold_mode = 1; w = cyc; fv_d_cnt = 0;
      dq.push_back(mk(1'b0, 16'h4321, 16'h0));
      wait_idle(100);
      chk("withdraw_dack_cycle", 32'(last_dack - w), 32'(12));
      chk("withdraw_words", 32'(fv_d_cnt), 32'(8));
      hold_mode = 0;

      // Reset in cycle 6 of an I fill abandons it.
      w = cyc;
      iq.push_back(mk(1'b0, 16'h0100, 16'h0));
      while (cyc < w + 6) tick();
      iq.delete();
      dq.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      fv_cnt = 0; iack_cnt = 0;
      repeat (20) tick();
      chk("rst_mid_no_fill", 32'(fv_cnt), 32'(0));
      chk("rst_mid_no_ack", 32'(iack_cnt), 32'(0));

      // i_req held through TURN: next grant lands at ack+2.
      w = cyc; iack_cnt = 0;
      iq.push_back(mk(1'b0, 16'h0200, 16'h0));
      iq.push_back(mk(1'b0, 16'h0300, 16'h0));
      wait_idle(200);
      chk("turn_second_ack", 32'(last_iack - w), 32'(26));
      chk("turn_ack_count", 32'(iack_cnt), 32'(2));

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         logic we_r;
         hold_mode = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) iq.push_back(mk(1'b0, 16'($urandom), 16'h0));
         if ($urandom_range(0, 1) == 1) begin
            we_r = 1'($urandom);
            dq.push_back(mk(we_r, we_r ? (16'($urandom) & 16'hFFFE) : 16'($urandom),
                            16'($urandom)));
         end
         repeat ($urandom_range(0, 15)) tick();
      end
      wait_idle(4000);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
